// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: a word SRAM with byte-lane
// writes, a fixed wait-state sequencer and out-of-range fault reporting.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wmask_q, wmask_d;
  logic            fault_q, fault_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [32:0]     offset;
  logic            in_fault;
  logic            accept;
  logic            commit;
  logic            c_we;
  logic            c_fault;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic [3:0]      c_wmask;

  // A borrow out of the offset subtraction means the address lies below the base.
  assign offset   = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_fault = offset[32] || (offset[31:0] >= SPAN);
  assign accept   = req && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_fault = fault_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_wmask = wmask_q;

    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      IDLE, RESP: begin
        if (accept) begin
          we_d    = we;
          idx_d   = offset[AW+1:2];
          wdata_d = wdata;
          wmask_d = wmask;
          fault_d = in_fault;
          if (WAIT_STATES == 0) begin
            // Zero wait states: the accept edge is also the commit edge, so use live inputs.
            state_d = RESP;
            commit  = 1'b1;
            c_we    = we;
            c_fault = in_fault;
            c_idx   = offset[AW+1:2];
            c_wdata = wdata;
            c_wmask = wmask;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      rdata_d = (c_we || c_fault) ? 32'h0 : mem[c_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset held across an edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (commit && !reset && c_we && !c_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wmask[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign stall = (state_q == WAIT);
  assign busy  = (state_q != IDLE);
  assign err   = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 3 and 2 wait states, one with a
// non-zero base) checked against a word-map model of the memory.
module tb_dmem_responder;

  localparam int          NI        = 3;
  localparam int          WS   [NI] = '{0, 3, 2};
  localparam int          DEPTH[NI] = '{1024, 1024, 64};
  localparam logic [31:0] BASE [NI] = '{32'h0, 32'h0, 32'h100};

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [NI];
  logic        we_s    [NI];
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic [3:0]  wmask_s [NI];
  logic [31:0] rdata_s [NI];
  logic        stall_s [NI];
  logic        err_s   [NI];
  logic        busy_s  [NI];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [NI];
  item_t       sq[$];
  logic [31:0] stream_last_obs;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .wmask(wmask_s[0]), .rdata(rdata_s[0]), .stall(stall_s[0]),
    .err(err_s[0]), .busy(busy_s[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .wmask(wmask_s[1]), .rdata(rdata_s[1]), .stall(stall_s[1]),
    .err(err_s[1]), .busy(busy_s[1]));

  dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h100), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]), .wmask(wmask_s[2]), .rdata(rdata_s[2]), .stall(stall_s[2]),
    .err(err_s[2]), .busy(busy_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a map of words keyed by instance and word offset from the base.
  task automatic model(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output bit e_err, output logic [31:0] e_rd);
    longint      off;
    int          key;
    logic [31:0] word;
    off   = longint'(a) - longint'(BASE[k]);
    e_err = (off < 0) || (off >= longint'(DEPTH[k]) * 4);
    e_rd  = 32'h0;
    if (!e_err) begin
      key = k * 65536 + int'(off / 4);
      if (w) begin
        word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) word[8*i +: 8] = d[8*i +: 8];
        ref_mem[key] = word;
      end else begin
        e_rd = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxx_xxxx;
      end
    end
  endtask

  task automatic drive(input int k, input item_t it);
    req_s[k]   = 1'b1;
    we_s[k]    = it.w;
    addr_s[k]  = it.a;
    wdata_s[k] = it.d;
    wmask_s[k] = it.m;
  endtask

  // One isolated transaction from IDLE; req is toggled at random while stalled.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd_obs);
    bit          e_err;
    logic [31:0] e_rd;
    item_t       it;
    it = '{w, a, d, m};
    @(negedge clk);
    chk("idle_busy", 32'(busy_s[k]), 32'h0);
    chk("idle_stall", 32'(stall_s[k]), 32'h0);
    chk("idle_err", 32'(err_s[k]), 32'h0);
    chk("idle_rdata_hold", rdata_s[k], last_rd[k]);
    drive(k, it);
    model(k, w, a, d, m, e_err, e_rd);
    @(posedge clk);
    for (int i = 0; i < WS[k]; i++) begin
      @(negedge clk);
      chk("wait_stall", 32'(stall_s[k]), 32'h1);
      chk("wait_err", 32'(err_s[k]), 32'h0);
      chk("wait_busy", 32'(busy_s[k]), 32'h1);
      chk("wait_rdata_hold", rdata_s[k], last_rd[k]);
      req_s[k] = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    chk("resp_stall", 32'(stall_s[k]), 32'h0);
    chk("resp_busy", 32'(busy_s[k]), 32'h1);
    chk("resp_err", 32'(err_s[k]), 32'(e_err));
    chk("resp_rdata", rdata_s[k], e_rd);
    rd_obs     = rdata_s[k];
    last_rd[k] = e_rd;
    req_s[k]   = 1'b0;
    @(posedge clk);
  endtask

  // Back-to-back issue of everything in sq on a zero-wait-state instance.
  task automatic stream(input int k);
    bit          e_err[$];
    logic [31:0] e_rd[$];
    bit          be;
    logic [31:0] br;
    int          n;
    n = sq.size();
    @(negedge clk);
    drive(k, sq[0]);
    model(k, sq[0].w, sq[0].a, sq[0].d, sq[0].m, be, br);
    e_err.push_back(be);
    e_rd.push_back(br);
    @(posedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("stream_stall", 32'(stall_s[k]), 32'h0);
      chk("stream_busy", 32'(busy_s[k]), 32'h1);
      chk("stream_err", 32'(err_s[k]), 32'(e_err[j]));
      chk("stream_rdata", rdata_s[k], e_rd[j]);
      stream_last_obs = rdata_s[k];
      last_rd[k]      = e_rd[j];
      if (j + 1 < n) begin
        drive(k, sq[j+1]);
        model(k, sq[j+1].w, sq[j+1].a, sq[j+1].d, sq[j+1].m, be, br);
        e_err.push_back(be);
        e_rd.push_back(br);
      end else begin
        req_s[k] = 1'b0;
      end
      @(posedge clk);
    end
    sq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] va;
    logic [31:0] vb;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_s[k]   = 1'b0;
      we_s[k]    = 1'b0;
      addr_s[k]  = 32'h0;
      wdata_s[k] = 32'h0;
      wmask_s[k] = 4'h0;
      last_rd[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_rdata", rdata_s[k], 32'h0);
      chk("reset_stall", 32'(stall_s[k]), 32'h0);
      chk("reset_err", 32'(err_s[k]), 32'h0);
      chk("reset_busy", 32'(busy_s[k]), 32'h0);
    end
    reset = 1'b0;

    // Store then load the same word on consecutive cycles.
    sq.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
    sq.push_back('{1'b0, 32'h10, 32'h0, 4'h0});
    stream(0);
    chk("st_ld_deadbeef", stream_last_obs, 32'hDEADBEEF);

    // Byte-lane merge.
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd);
    chk("byte_lane_merge", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd);
    txn(0, 1'b0, 32'h23, 32'h0, 4'h0, rd);
    chk("zero_mask_store", rd, 32'h11BB33DD);

    // Wait-state instance.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    chk("ws3_load", rd, 32'hDEADBEEF);

    // Range faults, including both boundaries.
    txn(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, rd);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd);
    chk("fault_load_rdata", rd, 32'h0);
    txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    chk("fault_store_no_alias", rd, 32'h55AA55AA);
    txn(2, 1'b0, 32'hFC, 32'h0, 4'h0, rd);
    txn(2, 1'b1, 32'h1FC, 32'h0BADCAFE, 4'hF, rd);
    txn(2, 1'b0, 32'h1FC, 32'h0, 4'h0, rd);
    chk("top_word_load", rd, 32'h0BADCAFE);
    txn(2, 1'b0, 32'h200, 32'h0, 4'h0, rd);

    // Reset in the first stall cycle of a store aborts it.
    txn(2, 1'b1, 32'h140, 32'hCAFEF00D, 4'hF, rd);
    @(negedge clk);
    drive(2, '{1'b1, 32'h140, 32'h12345678, 4'hF});
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_stall", 32'(stall_s[2]), 32'h1);
    reset    = 1'b1;
    req_s[2] = 1'b0;
    #1;
    chk("abort_stall", 32'(stall_s[2]), 32'h0);
    chk("abort_busy", 32'(busy_s[2]), 32'h0);
    chk("abort_err", 32'(err_s[2]), 32'h0);
    chk("abort_rdata", rdata_s[2], 32'h0);
    for (int k = 0; k < NI; k++) last_rd[k] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(2, 1'b0, 32'h140, 32'h0, 4'h0, rd);
    chk("abort_no_commit", rd, 32'hCAFEF00D);

    // Four-deep streaming with random data.
    for (int r = 0; r < 3; r++) begin
      va = $urandom;
      vb = $urandom;
      sq.push_back('{1'b1, 32'h0, va, 4'hF});
      sq.push_back('{1'b0, 32'h0, 32'h0, 4'h0});
      sq.push_back('{1'b1, 32'h4, vb, 4'hF});
      sq.push_back('{1'b0, 32'h4, 32'h0, 4'h0});
      stream(0);
      chk("stream_last_load", stream_last_obs, vb);
    end

    // Random mix on every instance.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 30; n++) begin
        int          idx;
        bit          w;
        bit          flt;
        logic [3:0]  m;
        logic [31:0] a;
        idx = $urandom_range(0, 7);
        flt = ($urandom_range(0, 5) == 0);
        w   = 1'($urandom_range(0, 1));
        m   = 4'($urandom_range(0, 15));
        if (flt) begin
          if (BASE[k] != 32'h0 && $urandom_range(0, 1) == 1)
            a = BASE[k] - 32'(4 * $urandom_range(1, 4));
          else
            a = BASE[k] + 32'(DEPTH[k] * 4) + 32'(4 * $urandom_range(0, 3));
        end else begin
          a = BASE[k] + 32'(4 * idx) + 32'($urandom_range(0, 3));
          if (!ref_mem.exists(k * 65536 + idx)) begin
            w = 1'b1;
            m = 4'hF;
          end
        end
        txn(k, w, a, $urandom, m, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
